mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the DPI memory controller (`MemContrl`). It accepts instruction-fetch (IFU) reads and load/store-unit (LSU) reads/writes over valid/ready handshakes and serialises them onto the single memory port. It emulates a configurable access latency and returns responses over a second valid/ready handshake. It sits between the IFU/LSU and `MemContrl` inside the NPC core.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_grant.sv | 59 +++++
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the mem_arbiter slice (IFU/LSU arbiter in front of MemContrl).
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between IFU and LSU requests.
// MEM_ARB_RR_EN selects round-robin contention handling; otherwise the LSU has fixed priority.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    ifu_valid_i,
    input  logic    lsu_valid_i,
    input  logic    accept_i,
    output logic    grant_valid_o,
    output req_id_t grant_id_o
);

`ifdef MEM_ARB_RR_EN
    req_id_t last_grant_q;

    // Remember who won the most recent accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= REQ_LSU;
        end else if (accept_i) begin
            last_grant_q <= grant_id_o;
        end else begin
            last_grant_q <= last_grant_q;
        end
    end

    // On contention, favour whoever did not win last time.
    always_comb begin
        grant_id_o = REQ_LSU;
        if (ifu_valid_i && lsu_valid_i) begin
            grant_id_o = (last_grant_q == REQ_LSU) ? REQ_IFU : REQ_LSU;
        end else if (ifu_valid_i) begin
            grant_id_o = REQ_IFU;
        end else begin
            grant_id_o = REQ_LSU;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{clk, reset, accept_i};

    // LSU wins whenever it is requesting.
    always_comb begin
        grant_id_o = REQ_LSU;
        if (lsu_valid_i) begin
            grant_id_o = REQ_LSU;
        end else if (ifu_valid_i) begin
            grant_id_o = REQ_IFU;
        end else begin
            grant_id_o = REQ_LSU;
        end
    end
`endif

    assign grant_valid_o = ifu_valid_i | lsu_valid_i;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer in front of MemContrl with emulated access latency.
// Optional build macro: MEM_ARB_RR_EN (round-robin grant instead of LSU priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_valid,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (LATENCY < 1) begin : g_bad_latency
        $error("mem_arbiter: LATENCY must be at least 1");
    end

    localparam int              CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_ACCESS = 2'(ACCESS);
    localparam logic [1:0] S_RESP   = 2'(RESP);

    logic [1:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    req_id_t           id_q,     id_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic              wen_q,    wen_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [MASK_W-1:0] wmask_q,  wmask_d;
    logic [DATA_W-1:0] resp_q,   resp_d;

    logic    grant_valid_s;
    req_id_t grant_id_s;
    logic    accept_s;
    logic    resp_ready_s;

    mem_arb_grant u_grant (
        .clk           (clk),
        .reset         (reset),
        .ifu_valid_i   (ifu_req_valid),
        .lsu_valid_i   (lsu_req_valid),
        .accept_i      (accept_s),
        .grant_valid_o (grant_valid_s),
        .grant_id_o    (grant_id_s)
    );

    assign accept_s     = (state_q == S_IDLE) && grant_valid_s;
    assign resp_ready_s = (id_q == REQ_IFU) ? ifu_resp_ready : lsu_resp_ready;

    // Transaction sequencing and payload/response capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        resp_d  = resp_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_ACCESS;
                    cnt_d   = CNT_LOAD;
                    id_d    = grant_id_s;
                    if (grant_id_s == REQ_LSU) begin
                        addr_d  = lsu_addr;
                        wen_d   = lsu_wen;
                        wdata_d = lsu_wdata;
                        wmask_d = lsu_wmask;
                    end else begin
                        addr_d  = ifu_addr;
                        wen_d   = 1'b0;
                        wdata_d = {DATA_W{1'b0}};
                        wmask_d = {MASK_W{1'b0}};
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_RESP;
                    resp_d  = wen_q ? {DATA_W{1'b0}} : mem_rdata;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RESP: begin
                if (resp_ready_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            id_q    <= REQ_IFU;
            addr_q  <= {ADDR_W{1'b0}};
            wen_q   <= 1'b0;
            wdata_q <= {DATA_W{1'b0}};
            wmask_q <= {MASK_W{1'b0}};
            resp_q  <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            resp_q  <= resp_d;
        end
    end

    assign ifu_req_ready  = accept_s && (grant_id_s == REQ_IFU);
    assign lsu_req_ready  = accept_s && (grant_id_s == REQ_LSU);
    assign ifu_resp_valid = (state_q == S_RESP) && (id_q == REQ_IFU);
    assign lsu_resp_valid = (state_q == S_RESP) && (id_q == REQ_LSU);
    assign ifu_rdata      = resp_q;
    assign lsu_rdata      = resp_q;

    // The write strobe is confined to the final access cycle.
    assign mem_valid = (state_q == S_ACCESS);
    assign mem_wen   = mem_valid && wen_q && (cnt_q == CNT_ZERO);
    assign mem_raddr = addr_q;
    assign mem_waddr = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (LATENCY=3) with a small backing-memory model.
module tb_mem_arbiter;
    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ifu_req_valid = 1'b0, ifu_req_ready;
    logic [31:0] ifu_addr = 32'h0;
    logic        ifu_resp_valid, ifu_resp_ready = 1'b1;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_addr = 32'h0, lsu_wdata = 32'h0;
    logic [7:0]  lsu_wmask = 8'h0;
    logic        lsu_resp_valid, lsu_resp_ready = 1'b1;
    logic [31:0] lsu_rdata;
    logic        mem_valid, mem_wen;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    logic [31:0] mem_arr [0:15] = '{0: 32'h0000_0413, 1: 32'h1111_0004, 2: 32'h2222_0008, default: 32'h0};
    int wen_cnt = 0;

    typedef struct { logic id; logic [31:0] data; } exp_t;
    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_arr[mem_raddr[5:2]];

    // Backing memory: apply byte-masked writes while the strobe is high.
    always @(negedge clk) begin
        if (mem_valid && mem_wen) begin
            wen_cnt <= wen_cnt + 1;
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) mem_arr[mem_waddr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_check(input logic id, input logic [31:0] data);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_resp: got id %0d data %h expected none", id, data);
        end else begin
            e = sb.pop_front();
            chk("resp_id", {31'h0, id}, {31'h0, e.id});
            chk("resp_data", data, e.data);
        end
    endtask

    // Monitor: a response is consumed when valid and ready are both high.
    always @(negedge clk) begin
        if (!reset) begin
            if (ifu_resp_valid && ifu_resp_ready) pop_check(1'b0, ifu_rdata);
            if (lsu_resp_valid && lsu_resp_ready) pop_check(1'b1, lsu_rdata);
        end
    end

    task automatic push_exp(input logic id, input logic [31:0] data);
        exp_t e;
        e.id = id;
        e.data = data;
        sb.push_back(e);
    endtask

    // Called at posedge+2; returns at posedge+2 just after the accepting edge.
    task automatic send(input logic is_lsu, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [7:0] wmask);
        logic ok;
        ok = 1'b0;
        if (is_lsu) begin
            lsu_addr = addr; lsu_wen = wen; lsu_wdata = wdata; lsu_wmask = wmask; lsu_req_valid = 1'b1;
        end else begin
            ifu_addr = addr; ifu_req_valid = 1'b1;
        end
        for (int g = 0; g < 50; g++) begin
            #1;
            if (is_lsu ? lsu_req_ready : ifu_req_ready) ok = 1'b1;
            @(posedge clk);
            #2;
            if (ok) break;
        end
        lsu_req_valid = 1'b0;
        ifu_req_valid = 1'b0;
        chk("req_accepted", {31'h0, ok}, 32'h1);
    endtask

    task automatic drain();
        for (int g = 0; g < 100; g++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        chk("drain_timeout", sb.size(), 32'h0);
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {24'h0, mem_valid, mem_wen, ifu_req_ready, lsu_req_ready,
                             ifu_resp_valid, lsu_resp_valid, 2'b00}, 32'h0);
        chk({tag, "_raddr"}, mem_raddr, 32'h0);
        chk({tag, "_waddr"}, mem_waddr, 32'h0);
        chk({tag, "_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_wmask"}, {24'h0, mem_wmask}, 32'h0);
        chk({tag, "_rdata"}, ifu_rdata | lsu_rdata, 32'h0);
    endtask

    initial begin
        int w0;
        int acc;
        // Reset state
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #2;

        // IFU read: ACCESS cycles 1..3, response in cycle 4
        push_exp(1'b0, 32'h0000_0413);
        send(1'b0, 1'b0, 32'h8000_0000, 32'h0, 8'h0);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            chk("rd_mem_valid", {31'h0, mem_valid}, (k <= LAT) ? 32'h1 : 32'h0);
            chk("rd_resp_valid", {31'h0, ifu_resp_valid}, (k == LAT + 1) ? 32'h1 : 32'h0);
            if (k == 1) chk("rd_raddr", mem_raddr, 32'h8000_0000);
        end
        drain();

        // LSU write: one strobe in the last access cycle, zero read data
        w0 = wen_cnt;
        push_exp(1'b1, 32'h0);
        send(1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            chk("wr_mem_wen", {31'h0, mem_wen}, (k == LAT) ? 32'h1 : 32'h0);
            if (k == 1) chk("wr_waddr", mem_waddr, 32'h8000_0010);
        end
        drain();
        chk("wr_pulse_count", wen_cnt - w0, 32'h1);
        push_exp(1'b1, 32'hDEAD_BEEF);
        send(1'b1, 1'b0, 32'h8000_0010, 32'h0, 8'h0);
        drain();

        // Contention for four transactions
`ifdef MEM_ARB_RR_EN
        push_exp(1'b0, 32'h1111_0004);
        push_exp(1'b1, 32'h2222_0008);
        push_exp(1'b0, 32'h1111_0004);
        push_exp(1'b1, 32'h2222_0008);
`else
        for (int i = 0; i < 4; i++) push_exp(1'b1, 32'h2222_0008);
`endif
        ifu_addr = 32'h8000_0004;
        lsu_addr = 32'h8000_0008;
        lsu_wen = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        acc = 0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if ((ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready)) acc++;
            if (acc == 4) begin
                @(posedge clk); #2;
                ifu_req_valid = 1'b0;
                lsu_req_valid = 1'b0;
                break;
            end
        end
        chk("contention_accepts", acc, 32'h4);
        drain();

        // Response backpressure with a waiting IFU request
        lsu_resp_ready = 1'b0;
        push_exp(1'b1, 32'h1111_0004);
        send(1'b1, 1'b0, 32'h8000_0004, 32'h0, 8'h0);
        push_exp(1'b0, 32'h0000_0413);
        ifu_addr = 32'h8000_0000;
        ifu_req_valid = 1'b1;
        for (int k = 1; k <= LAT + 5; k++) begin
            @(negedge clk);
            chk("bp_ifu_ready", {31'h0, ifu_req_ready}, 32'h0);
            if (k > LAT) begin
                chk("bp_resp_valid", {31'h0, lsu_resp_valid}, 32'h1);
                chk("bp_rdata", lsu_rdata, 32'h1111_0004);
            end
        end
        @(posedge clk); #2;
        lsu_resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ifu_ready_hs", {31'h0, ifu_req_ready}, 32'h0);
        @(negedge clk);
        chk("bp_ifu_ready_after", {31'h0, ifu_req_ready}, 32'h1);
        @(posedge clk); #2;
        ifu_req_valid = 1'b0;
        drain();

        // Reset in cycle 1 of a write drops it entirely
        w0 = wen_cnt;
        send(1'b1, 1'b1, 32'h8000_0020, 32'h1234_5678, 8'h0F);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #2;
        chk("rst_no_wen", wen_cnt - w0, 32'h0);
        chk("rst_mem_unchanged", mem_arr[8], 32'h0);
        push_exp(1'b1, 32'hDEAD_BEEF);
        send(1'b1, 1'b0, 32'h8000_0010, 32'h0, 8'h0);
        drain();
        chk("sb_empty", sb.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
